// File: rtl/comparator_pkg.sv
// Shared types and helpers for the comparator BIST slice.
// State encoding, flag bit positions and the golden compare function.
package comparator_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  localparam int LT_IDX = 2;
  localparam int GT_IDX = 1;
  localparam int EQ_IDX = 0;

  function automatic logic [2:0] cmp_flags(
    input int unsigned a,
    input int unsigned b
  );
    logic [2:0] f;
    f         = '0;
    f[LT_IDX] = (a < b);
    f[GT_IDX] = (a > b);
    f[EQ_IDX] = (a == b);
    return f;
  endfunction

endpackage

// File: rtl/comparator_ref_model.sv
// Combinational golden model of an unsigned N-bit magnitude comparator.
// Flags are packed {Lesser,Greater,Equal}.
module comparator_ref_model
  import comparator_pkg::*;
#(
  parameter int N = 3
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  output logic [2:0]   flags
);

  assign flags = cmp_flags(32'(a), 32'(b));

endmodule

// File: rtl/comparator_bist.sv
// Exhaustive-sweep BIST controller for comparator_nbit.
// Drives A/B, checks returned flags, records error count and first failure.
module comparator_bist
  import comparator_pkg::*;
#(
  parameter int N = 3
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic         abort,
  output logic [N-1:0] A,
  output logic [N-1:0] B,
  input  logic         Lesser,
  input  logic         Greater,
  input  logic         Equal,
  output logic         busy,
  output logic         done,
  output logic         pass,
  output logic [2*N:0] err_count,
  output logic         fail_valid,
  output logic [N-1:0] fail_a,
  output logic [N-1:0] fail_b,
  output logic [2:0]   fail_flags
);

  localparam logic [N-1:0] OP_ONE  = {{(N-1){1'b0}}, 1'b1};
  localparam logic [2*N:0] ERR_ONE = {{(2*N){1'b0}}, 1'b1};

  state_t     state;
  state_t     state_n;
  logic [2:0] exp_flags;
  logic [2:0] obs_flags;
  logic       mism;
  logic       last;
  logic       launch;
  logic       check;

  comparator_ref_model #(
    .N(N)
  ) u_ref (
    .a    (A),
    .b    (B),
    .flags(exp_flags)
  );

  assign obs_flags = {Lesser, Greater, Equal};
  assign mism      = (obs_flags != exp_flags);
  assign last      = (&A) & (&B);
  assign launch    = start & ((state == IDLE) | (state == DONE));
  assign check     = (state == RUN) & ~abort;

  assign busy = (state == RUN);
  assign done = (state == DONE);
  assign pass = done & (err_count == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_n;
  end

  always_comb begin
    state_n = state;
    unique case (state)
      IDLE: if (start) state_n = RUN;
      RUN: begin
        if (abort)     state_n = IDLE;
        else if (last) state_n = DONE;
      end
      DONE: if (start) state_n = RUN;
      default: state_n = IDLE;
    endcase
  end

  // B is the inner loop, A the outer; both hold on the final vector.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      A          <= '0;
      B          <= '0;
      err_count  <= '0;
      fail_valid <= 1'b0;
      fail_a     <= '0;
      fail_b     <= '0;
      fail_flags <= '0;
    end else if (launch) begin
      A          <= '0;
      B          <= '0;
      err_count  <= '0;
      fail_valid <= 1'b0;
      fail_a     <= '0;
      fail_b     <= '0;
      fail_flags <= '0;
    end else if (check) begin
      if (mism) begin
        err_count <= err_count + ERR_ONE;
        if (!fail_valid) begin
          fail_valid <= 1'b1;
          fail_a     <= A;
          fail_b     <= B;
          fail_flags <= obs_flags;
        end
      end
      if (!last) begin
        if (&B) begin
          B <= '0;
          A <= A + OP_ONE;
        end else begin
          B <= B + OP_ONE;
        end
      end
    end
  end

endmodule
